// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory arbiter
//
// Holds the arbiter FSM state encoding and the default address/data/lane widths.
// Optional feature macro used by the bundle: MEM_ARB_IBUF_EN (one-entry fetch buffer).

package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - request/response and shared-memory bundle for mem_arbiter
//
// Signals:
//   fetch port : if_req, if_addr -> if_ready, if_inst
//   data port  : dm_req, dm_we, dm_addr, dm_sel, dm_wdata -> dm_ready, dm_rdata
//   memory     : mem_req, mem_we, mem_addr, mem_sel, mem_wdata <- mem_ack, mem_rdata
//   control    : stall_req
// Modports:
//   slave  - the arbiter's view (requests in, responses and memory commands out)
//   master - the environment's view (requesters plus memory model)

interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_inst;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [SEL_W-1:0]  dm_sel;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [SEL_W-1:0]  mem_sel;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_req;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_sel, dm_wdata,
        input  mem_ack, mem_rdata,
        output if_ready, if_inst,
        output dm_ready, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        output stall_req
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_sel, dm_wdata,
        output mem_ack, mem_rdata,
        input  if_ready, if_inst,
        input  dm_ready, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        input  stall_req
    );

endinterface

// File: rtl/mem_arb_ibuf.sv
// rtl/mem_arb_ibuf.sv - one-entry instruction fetch buffer {valid, addr, inst}
//
// Instantiated by mem_arbiter only when MEM_ARB_IBUF_EN is defined.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   i_fill          a memory fetch completed this cycle (capture i_fill_addr/i_fill_inst)
//   i_clear         a store completed this cycle (buffer may be stale, drop it)
//   i_lookup_addr   address being requested by the fetch port
//   o_hit           entry valid and its address equals i_lookup_addr
//   o_inst          buffered instruction

module mem_arb_ibuf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_fill,
    input  logic [ADDR_W-1:0] i_fill_addr,
    input  logic [DATA_W-1:0] i_fill_inst,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_inst
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_inst;

    // Fill and clear come from different served ports, so they never coincide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_inst  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_addr  <= i_fill_addr;
            r_inst  <= i_fill_inst;
        end
    end

    assign o_hit  = r_valid && (r_addr == i_lookup_addr);
    assign o_inst = r_inst;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data ports onto one registered memory port
//
// Ports:
//   clk   clock, all state on the rising edge
//   rst   synchronous active-low reset
//   bus   mem_arb_if.slave: fetch port, data port, shared memory port, stall_req
// Data requests win over fetches in IDLE. A grant registers the command onto mem_*,
// which stays stable until mem_ack; the served port then gets a one-cycle ready pulse.
// Optional macro MEM_ARB_IBUF_EN adds a one-entry fetch buffer (mem_arb_ibuf).

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [SEL_W-1:0]  r_mem_sel;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ready;
    logic              r_dm_ready;
    logic [DATA_W-1:0] r_if_inst;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_dm_req_eff;
    logic              w_if_req_eff;
    logic              w_grant_dm;
    logic              w_grant_if;
    logic              w_hit_take;
    logic              w_done;
    logic              w_fetch_done;
    logic              w_dm_done;
    logic              w_store_done;
    logic              w_hit;
    logic [DATA_W-1:0] w_buf_inst;

    // A requester keeps req high through its ready cycle; masking with our own
    // ready pulse stops that cycle from starting a second service.
    assign w_dm_req_eff = bus.dm_req & ~r_dm_ready;
    assign w_if_req_eff = bus.if_req & ~r_if_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_dm  = 1'b0;
        w_grant_if  = 1'b0;
        w_hit_take  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                // mem_ack seen here is stray and deliberately ignored.
                if (w_dm_req_eff) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = SERVE_DM;
                end else if (w_if_req_eff) begin
                    if (w_hit) begin
                        w_hit_take = 1'b1;
                    end else begin
                        w_grant_if  = 1'b1;
                        w_state_nxt = SERVE_IF;
                    end
                end
            end
            SERVE_IF, SERVE_DM: begin
                if (bus.mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_fetch_done = w_done && (r_state == SERVE_IF);
    assign w_dm_done    = w_done && (r_state == SERVE_DM);
    assign w_store_done = w_dm_done && r_mem_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_sel   <= '0;
            r_mem_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_if_inst   <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_ready <= w_fetch_done || w_hit_take;
            r_dm_ready <= w_dm_done;

            if (w_grant_dm) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= bus.dm_we;
                r_mem_addr  <= bus.dm_addr;
                r_mem_sel   <= bus.dm_sel;
                r_mem_wdata <= bus.dm_wdata;
            end else if (w_grant_if) begin
                // Fetches are full-word reads; lanes and wdata get fixed values.
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= bus.if_addr;
                r_mem_sel   <= '1;
                r_mem_wdata <= '0;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
            end

            if (w_fetch_done) begin
                r_if_inst <= bus.mem_rdata;
            end else if (w_hit_take) begin
                r_if_inst <= w_buf_inst;
            end

            if (w_dm_done && !r_mem_we) begin
                r_dm_rdata <= bus.mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_IBUF_EN
    mem_arb_ibuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ibuf (
        .clk           (clk),
        .rst           (rst),
        .i_fill        (w_fetch_done),
        .i_fill_addr   (r_mem_addr),
        .i_fill_inst   (bus.mem_rdata),
        .i_clear       (w_store_done),
        .i_lookup_addr (bus.if_addr),
        .o_hit         (w_hit),
        .o_inst        (w_buf_inst)
    );
`else
    assign w_hit      = 1'b0;
    assign w_buf_inst = '0;
`endif

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_sel   = r_mem_sel;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.if_inst   = r_if_inst;
    assign bus.dm_ready  = r_dm_ready;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.stall_req = (bus.if_req & ~r_if_ready) | (bus.dm_req & ~r_dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (directed + randomized)

module tb_mem_arbiter;

`ifdef MEM_ARB_IBUF_EN
    localparam bit IBUF = 1'b1;
`else
    localparam bit IBUF = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   rand_phase = 1'b0;

    mem_arb_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backing memory of the environment.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] memread(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] sel,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding memory command at most,
    // data port preferred, ready port ignored for one cycle, optional fetch buffer.
    bit          m_known = 1'b0;
    bit          m_busy, m_port_dm, m_we, m_if_rdy, m_dm_rdy, m_bvalid;
    logic [31:0] m_addr, m_wdata, m_if_inst, m_dm_rdata, m_baddr, m_binst;
    logic [3:0]  m_sel;
    logic [31:0] dm_exp_store;

    task automatic model_step();
        bit n_if, n_dm;
        n_if = 1'b0;
        n_dm = 1'b0;
        if (!rst) begin
            m_known = 1'b1; m_busy = 1'b0; m_port_dm = 1'b0; m_we = 1'b0;
            m_if_rdy = 1'b0; m_dm_rdy = 1'b0; m_bvalid = 1'b0;
            m_addr = '0; m_wdata = '0; m_sel = '0; m_if_inst = '0; m_dm_rdata = '0;
            m_baddr = '0; m_binst = '0;
            return;
        end
        if (!m_known) return;
        if (m_busy) begin
            if (bus.mem_ack) begin
                m_busy = 1'b0;
                if (m_port_dm) begin
                    n_dm = 1'b1;
                    if (m_we) m_bvalid = 1'b0;
                    else      m_dm_rdata = bus.mem_rdata;
                end else begin
                    n_if      = 1'b1;
                    m_if_inst = bus.mem_rdata;
                    m_bvalid  = 1'b1;
                    m_baddr   = m_addr;
                    m_binst   = bus.mem_rdata;
                end
            end
        end else if (bus.dm_req && !m_dm_rdy) begin
            m_busy = 1'b1; m_port_dm = 1'b1; m_we = bus.dm_we;
            m_addr = bus.dm_addr; m_sel = bus.dm_sel; m_wdata = bus.dm_wdata;
        end else if (bus.if_req && !m_if_rdy) begin
            if (IBUF && m_bvalid && m_baddr == bus.if_addr) begin
                n_if      = 1'b1;
                m_if_inst = m_binst;
            end else begin
                m_busy = 1'b1; m_port_dm = 1'b0; m_we = 1'b0;
                m_addr = bus.if_addr; m_sel = 4'hF; m_wdata = '0;
            end
        end
        m_if_rdy = n_if;
        m_dm_rdy = n_dm;
    endtask

    // Compare process: every negedge, DUT outputs against the model, then advance.
    initial begin
        forever begin
            @(negedge clk);
            if (m_known) begin
                chk1 ("mem_req",   bus.mem_req,   m_busy);
                chk1 ("mem_we",    bus.mem_we,    m_we);
                chk32("mem_addr",  bus.mem_addr,  m_addr);
                chk32("mem_sel",   {28'd0, bus.mem_sel}, {28'd0, m_sel});
                chk32("mem_wdata", bus.mem_wdata, m_wdata);
                chk1 ("if_ready",  bus.if_ready,  m_if_rdy);
                chk1 ("dm_ready",  bus.dm_ready,  m_dm_rdy);
                chk32("if_inst",   bus.if_inst,   m_if_inst);
                chk32("dm_rdata",  bus.dm_rdata,  m_dm_rdata);
                chk1 ("stall_req", bus.stall_req,
                      (bus.if_req & ~m_if_rdy) | (bus.dm_req & ~m_dm_rdy));
                if (rand_phase && bus.if_ready)
                    chk32("fetch_data", bus.if_inst, memread(bus.if_addr));
                if (rand_phase && bus.dm_ready && !bus.dm_we)
                    chk32("load_data", bus.dm_rdata, memread(bus.dm_addr));
                if (rand_phase && bus.dm_ready && bus.dm_we)
                    chk32("store_data", memread(bus.dm_addr), dm_exp_store);
            end
            if (rst && bus.mem_req && bus.mem_ack && bus.mem_we)
                mem[bus.mem_addr] = merge(memread(bus.mem_addr), bus.mem_sel, bus.mem_wdata);
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] addrs [6] = '{32'h0, 32'h40, 32'h80, 32'h100, 32'h200, 32'h40};

    initial begin
        bit if_act, dm_act, s_if, s_dm;
        logic [31:0] a;
        rst = 1'b0;
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_sel = 0; bus.dm_wdata = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        repeat (3) tick();
        chk1 ("rst_mem_req",  bus.mem_req, 1'b0);
        chk1 ("rst_if_ready", bus.if_ready, 1'b0);
        chk1 ("rst_dm_ready", bus.dm_ready, 1'b0);
        chk32("rst_mem_addr", bus.mem_addr, 32'h0);
        chk32("rst_if_inst",  bus.if_inst, 32'h0);
        rst = 1'b1;
        tick();

        // Load, ack in the first mem_req cycle.
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100;
        tick();
        chk1 ("ld_mem_req", bus.mem_req, 1'b1);
        chk32("ld_mem_addr", bus.mem_addr, 32'h100);
        chk1 ("ld_ready_early", bus.dm_ready, 1'b0);
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk1 ("ld_ready", bus.dm_ready, 1'b1);
        chk32("ld_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        chk1 ("ld_mem_req_off", bus.mem_req, 1'b0);
        bus.dm_req = 0; bus.mem_ack = 0;
        tick();
        chk1 ("ld_ready_pulse", bus.dm_ready, 1'b0);

        // Simultaneous fetch and store: store first, fetch right after the ready cycle.
        bus.if_req = 1; bus.if_addr = 32'h0;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h200; bus.dm_sel = 4'hF;
        bus.dm_wdata = 32'h1234_5678;
        tick();
        chk1 ("sim_mem_we", bus.mem_we, 1'b1);
        chk32("sim_mem_addr", bus.mem_addr, 32'h200);
        chk32("sim_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        chk1 ("sim_stall1", bus.stall_req, 1'b1);
        bus.mem_ack = 1;
        tick();
        chk1 ("sim_dm_ready", bus.dm_ready, 1'b1);
        chk32("sim_rdata_hold", bus.dm_rdata, 32'hDEAD_BEEF);
        chk1 ("sim_stall2", bus.stall_req, 1'b1);
        bus.mem_ack = 0;
        tick();
        chk1 ("sim_fetch_req", bus.mem_req, 1'b1);
        chk32("sim_fetch_addr", bus.mem_addr, 32'h0);
        chk1 ("sim_fetch_we", bus.mem_we, 1'b0);
        chk1 ("sim_stall3", bus.stall_req, 1'b1);
        bus.dm_req = 0; bus.dm_we = 0;
        bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0013;
        tick();
        chk1 ("sim_if_ready", bus.if_ready, 1'b1);
        chk32("sim_if_inst", bus.if_inst, 32'h0000_0013);
        bus.if_req = 0; bus.mem_ack = 0;
        tick();

        // Ack delayed five cycles.
        bus.if_req = 1; bus.if_addr = 32'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1 ("dly_mem_req", bus.mem_req, 1'b1);
            chk32("dly_mem_addr", bus.mem_addr, 32'h80);
            chk1 ("dly_if_ready", bus.if_ready, 1'b0);
        end
        bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0093;
        tick();
        chk1 ("dly_ready", bus.if_ready, 1'b1);
        chk32("dly_inst", bus.if_inst, 32'h0000_0093);
        chk1 ("dly_mem_req_off", bus.mem_req, 1'b0);
        bus.mem_ack = 0;
        tick();
        chk1 ("dly_ready_pulse", bus.if_ready, 1'b0);
        chk1 ("dly_no_reissue", bus.mem_req, 1'b0);
        bus.if_req = 0;
        tick();

        // Reset mid-fetch, then a late ack.
        bus.if_req = 1; bus.if_addr = 32'hC0;
        tick();
        chk1 ("rmid_mem_req", bus.mem_req, 1'b1);
        rst = 1'b0;
        tick();
        chk1 ("rmid_mem_req_off", bus.mem_req, 1'b0);
        chk1 ("rmid_if_ready", bus.if_ready, 1'b0);
        chk32("rmid_if_inst", bus.if_inst, 32'h0);
        chk32("rmid_dm_rdata", bus.dm_rdata, 32'h0);
        rst = 1'b1; bus.if_req = 0; bus.mem_ack = 1;
        tick();
        chk1 ("rlate_mem_req", bus.mem_req, 1'b0);
        chk1 ("rlate_if_ready", bus.if_ready, 1'b0);
        bus.mem_ack = 0;
        tick();
        chk1 ("rlate_if_ready2", bus.if_ready, 1'b0);

        // Repeated fetch of 0x40, then a store, then 0x40 again.
        bus.if_req = 1; bus.if_addr = 32'h40;
        tick();
        chk1 ("buf1_mem_req", bus.mem_req, 1'b1);
        bus.mem_ack = 1; bus.mem_rdata = 32'hA5A5_0040;
        tick();
        chk1 ("buf1_ready", bus.if_ready, 1'b1);
        bus.mem_ack = 0; bus.if_req = 0;
        tick();
        bus.if_req = 1;
        tick();
        chk1 ("buf2_mem_req", bus.mem_req, !IBUF);
        chk1 ("buf2_ready", bus.if_ready, IBUF);
        if (bus.mem_req) begin
            bus.mem_ack = 1;
            tick();
            bus.mem_ack = 0;
        end
        chk1 ("buf2_ready_final", bus.if_ready, 1'b1);
        chk32("buf2_inst", bus.if_inst, 32'hA5A5_0040);
        bus.if_req = 0;
        tick();
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h300; bus.dm_sel = 4'h3;
        bus.dm_wdata = 32'h0000_1111;
        tick();
        bus.mem_ack = 1;
        tick();
        chk1 ("buf_st_ready", bus.dm_ready, 1'b1);
        bus.mem_ack = 0; bus.dm_req = 0; bus.dm_we = 0;
        tick();
        bus.if_req = 1;
        tick();
        chk1 ("buf3_mem_req", bus.mem_req, 1'b1);
        bus.mem_ack = 1;
        tick();
        chk1 ("buf3_ready", bus.if_ready, 1'b1);
        bus.mem_ack = 0; bus.if_req = 0;
        tick();

        // Randomized traffic with a backing memory and occasional resets.
        rand_phase = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        if_act = 1'b0;
        dm_act = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            #1;
            s_if = bus.if_ready;
            s_dm = bus.dm_ready;
            @(posedge clk);
            #1;
            if (if_act && s_if) begin if_act = 1'b0; bus.if_req = 0; end
            if (dm_act && s_dm) begin dm_act = 1'b0; bus.dm_req = 0; bus.dm_we = 0; end
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1'b1;
                bus.if_req  = 1;
                bus.if_addr = addrs[$urandom_range(0, 5)];
            end
            if (!dm_act && $urandom_range(0, 3) == 0) begin
                dm_act = 1'b1;
                a = addrs[$urandom_range(0, 5)];
                bus.dm_req   = 1;
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_addr  = a;
                bus.dm_sel   = 4'($urandom_range(1, 15));
                bus.dm_wdata = $urandom;
                dm_exp_store = merge(memread(a), bus.dm_sel, bus.dm_wdata);
            end
            if (bus.mem_req && $urandom_range(0, 2) == 0) begin
                bus.mem_ack   = 1;
                bus.mem_rdata = bus.mem_we ? $urandom : memread(bus.mem_addr);
            end else begin
                bus.mem_ack   = (!bus.mem_req && $urandom_range(0, 7) == 0);
                bus.mem_rdata = $urandom;
            end
            rst = ($urandom_range(0, 399) != 0);
        end
        rst = 1'b1;
        bus.if_req = 0; bus.dm_req = 0; bus.mem_ack = 0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width of all address ports.
REQ-002 Parameter DATA_W, default 32, data width of all data ports.
REQ-003 Parameter SEL_W, default 4, byte-lane select width (DATA_W/8).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 if_req  in  1  instruction-fetch request; held high until if_ready.
REQ-007 if_addr  in  ADDR_W  fetch address, stable while if_req high.
REQ-008 if_ready  out  1  one-cycle pulse; if_inst valid.
REQ-009 if_inst  out  DATA_W  fetched instruction.
REQ-010 dm_req  in  1  data-access request; held high until dm_ready.
REQ-011 dm_we  in  1  1 = store, 0 = load.
REQ-012 dm_addr  in  ADDR_W  data address.
REQ-013 dm_sel  in  SEL_W  store byte lanes.
REQ-014 dm_wdata  in  DATA_W  store data.
REQ-015 dm_ready  out  1  one-cycle pulse; access done, dm_rdata valid for loads.
REQ-016 dm_rdata  out  DATA_W  load data.
REQ-017 mem_req, mem_we, mem_addr, mem_sel, mem_wdata  out  1/1/ADDR_W/SEL_W/DATA_W  shared memory port, all registered.
REQ-018 mem_ack  in  1  memory completion, may assert in the first mem_req cycle.
REQ-019 mem_rdata  in  DATA_W  read data, valid with mem_ack.
REQ-020 stall_req  out  1  pipeline stall request to the controller.

Function
REQ-021 The FSM SHALL have states IDLE, SERVE_IF and SERVE_DM.
REQ-022 In IDLE, dm_req SHALL take priority: dm_req -> SERVE_DM, else if_req -> SERVE_IF, else stay IDLE.
REQ-023 On grant the requester's address/we/sel/wdata SHALL be latched onto mem_* and mem_req SHALL be 1 from the next cycle.
REQ-024 In SERVE_x, mem_req and mem_* SHALL stay stable until the cycle mem_ack=1.
REQ-025 After mem_ack, the next cycle SHALL have mem_req=0, the state IDLE and a one-cycle ready pulse to the served port.
REQ-026 Minimum latency SHALL be 2 cycles from req sampled to ready high.
REQ-027 For loads and fetches, mem_rdata SHALL be registered into dm_rdata/if_inst at mem_ack. For stores, dm_rdata SHALL hold its value.
REQ-028 In IDLE the arbiter SHALL ignore the req of a port whose ready is high in that cycle, preventing double service.
REQ-029 A grant is possible in the ready cycle, so back-to-back transactions SHALL be issued with no idle bubble.
REQ-030 mem_ack while in IDLE SHALL be ignored.
REQ-031 stall_req SHALL equal (if_req & ~if_ready) | (dm_req & ~dm_ready), combinationally.
REQ-032 A losing fetch SHALL wait. There is no starvation guarantee beyond the dm stall draining the pipeline.

Reset
REQ-033 When rst=0 at an edge, the state SHALL become IDLE and mem_req, if_ready and dm_ready SHALL become 0.
REQ-034 Reset SHALL also clear mem_we, mem_addr, mem_sel, mem_wdata, if_inst and dm_rdata to 0, and clear the buffer valid bit.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no ready pulse; a later mem_ack SHALL be ignored.

Configuration
REQ-036 With MEM_ARB_IBUF_EN defined, a one-entry fetch buffer {valid, addr, inst} SHALL be filled on every completed fetch.
REQ-037 Buffer hit rule: in IDLE, if_req with no dm_req and valid with addr==if_addr.
REQ-038 On a hit, if_ready SHALL pulse the next cycle with the buffered inst and no mem_req.
REQ-039 Any completed store SHALL clear valid.
REQ-040 Without MEM_ARB_IBUF_EN, every fetch SHALL access memory and no buffer logic SHALL exist.

Structure
REQ-041 Package mem_arb_pkg SHALL hold the FSM state enum and the default width constants.
REQ-042 The fetch buffer SHALL be sub-module mem_arb_ibuf, instantiated only under MEM_ARB_IBUF_EN.

Verification
REQ-043 Load with ack on the first mem_req cycle: dm_req, dm_addr=0x100, ack, mem_rdata=0xDEADBEEF -> dm_ready 2 cycles after req, dm_rdata=0xDEADBEEF.
REQ-044 Simultaneous requests: if_req (0x0) and dm_req (store 0x200, sel=0xF, 0x12345678) -> store issued first. Fetch issued in dm_ready cycle+1. stall_req high throughout.
REQ-045 Ack delayed 5 cycles: mem_* stable for all 5 cycles. if_ready exactly one cycle. No second mem_req for the same request.
REQ-046 Reset: rst=0 while in SERVE_IF, then mem_ack -> mem_req=0 next cycle, no if_ready, state IDLE.
REQ-047 With MEM_ARB_IBUF_EN: fetch 0x40 twice -> second served without mem_req. A store, then fetch 0x40 again -> memory access.
